// File: rtl/framebuffer_pingpong_pkg.sv
// framebuffer_pingpong_pkg: shared raster geometry helpers for the framebuffer and Sobel blocks
package framebuffer_pingpong_pkg;
  localparam int DEF_WIDTH = 160;
  localparam int DEF_HEIGHT = 120;
  localparam int DEF_DATA_WIDTH = 8;
  function automatic int bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/contador_raster.sv
// contador_raster: column-first raster counter with linear address and last-pixel flag
module contador_raster
  import framebuffer_pingpong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  localparam int COL_BITS = bits(WIDTH),
  localparam int ROW_BITS = bits(HEIGHT),
  localparam int ADDR_BITS = bits(WIDTH * HEIGHT)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 zera_s,
  input  logic                 conta,
  output logic [COL_BITS-1:0]  coluna,
  output logic [ROW_BITS-1:0]  fileira,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 fim_imagem
);
  localparam logic [COL_BITS-1:0] COL_MAX = COL_BITS'(WIDTH - 1);
  localparam logic [ROW_BITS-1:0] ROW_MAX = ROW_BITS'(HEIGHT - 1);
  logic fim_col, fim_row;
  assign fim_col = coluna == COL_MAX;
  assign fim_row = fileira == ROW_MAX;
  assign fim_imagem = fim_col & fim_row;
  assign addr = ADDR_BITS'(fileira) * ADDR_BITS'(WIDTH) + ADDR_BITS'(coluna);
  always_ff @(posedge clock) begin
    if (reset || zera_s) begin
      coluna <= '0;
      fileira <= '0;
    end else if (conta) begin
      coluna <= fim_col ? '0 : coluna + 1'b1;
      fileira <= fim_col ? (fim_row ? '0 : fileira + 1'b1) : fileira;
    end
  end
endmodule

// File: rtl/framebuffer_pingpong.sv
// framebuffer_pingpong: two-bank raster framebuffer; producer fills one bank while the consumer drains the other
module framebuffer_pingpong
  import framebuffer_pingpong_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int COL_BITS = bits(WIDTH),
  localparam int ROW_BITS = bits(HEIGHT),
  localparam int ADDR_BITS = bits(WIDTH * HEIGHT),
  localparam int SIZE = WIDTH * HEIGHT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_reinicia,
  output logic                  wr_fim_imagem,
  input  logic                  rd_incrementa,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic [COL_BITS-1:0]   out_coluna,
  output logic [ROW_BITS-1:0]   out_fileira,
  output logic                  rd_fim_imagem
);
  logic [DATA_WIDTH-1:0] bank0 [SIZE];
  logic [DATA_WIDTH-1:0] bank1 [SIZE];
  logic sel, w_full, rd_has_frame;
  logic [COL_BITS-1:0] w_col, r_col;
  logic [ROW_BITS-1:0] w_row, r_row;
  logic [ADDR_BITS-1:0] w_addr, r_addr;
  logic w_fim, r_fim, w_acc, r_acc, w_last, r_last, swap;
  logic unused_wpos;
  assign unused_wpos = ^{w_col, w_row};
  assign wr_ready = ~w_full;
  assign rd_ready = rd_has_frame;
  assign w_acc = wr_valid & ~w_full & ~wr_reinicia;
  assign r_acc = rd_incrementa & rd_has_frame;
  assign w_last = w_acc & w_fim;
  assign r_last = r_acc & r_fim;
  assign swap = w_full & (~rd_has_frame | r_last);
  contador_raster #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_wr (
    .clock(clock), .reset(reset), .zera_s(wr_reinicia), .conta(w_acc),
    .coluna(w_col), .fileira(w_row), .addr(w_addr), .fim_imagem(w_fim)
  );
  contador_raster #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_rd (
    .clock(clock), .reset(reset), .zera_s(1'b0), .conta(r_acc),
    .coluna(r_col), .fileira(r_row), .addr(r_addr), .fim_imagem(r_fim)
  );
  // sel=0: bank0 is written, bank1 is read
  always_ff @(posedge clock) begin
    if (w_acc && !sel) bank0[w_addr] <= data_in;
    if (w_acc && sel) bank1[w_addr] <= data_in;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sel <= 1'b0;
      w_full <= 1'b0;
      rd_has_frame <= 1'b0;
      wr_fim_imagem <= 1'b0;
      data_out <= '0;
      data_out_valid <= 1'b0;
      out_coluna <= '0;
      out_fileira <= '0;
      rd_fim_imagem <= 1'b0;
    end else begin
      sel <= sel ^ swap;
      w_full <= swap ? 1'b0 : (w_full | w_last);
      rd_has_frame <= swap ? 1'b1 : (rd_has_frame & ~r_last);
      wr_fim_imagem <= w_last;
      data_out_valid <= r_acc;
      rd_fim_imagem <= r_last;
      if (r_acc) begin
        data_out <= sel ? bank0[r_addr] : bank1[r_addr];
        out_coluna <= r_col;
        out_fileira <= r_row;
      end
    end
  end
endmodule
